// File: rtl/desired_drive_core.sv
// rtl/desired_drive_core.sv - pedal-assist desired motor current from torque, cadence, incline and assist level
// Optional macro DESIRED_DRIVE_PIPE_EN registers target_curr (one-cycle latency); default build is combinational.
module desired_drive_core #(
  parameter logic [11:0] TORQUE_MIN = 12'h380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] avg_torque,
  input  logic [4:0]  cadence,
  input  logic        not_pedaling,
  input  logic [12:0] incline,
  input  logic [2:0]  scale,
  output logic [11:0] target_curr
);

  logic signed [9:0]  incline_sat;
  logic signed [10:0] incline_factor;
  logic [8:0]         incline_lim;
  logic [5:0]         cadence_factor;
  logic [12:0]        torque_off;
  logic [11:0]        torque_pos;
  logic [29:0]        assist_prod;
  logic [11:0]        target_next;

  always_comb begin
    incline_sat = incline[9:0];
    if ($signed(incline) > 13'sd511)
      incline_sat = 10'sd511;
    else if ($signed(incline) < -13'sd512)
      incline_sat = -10'sd512;
  end

  assign incline_factor = {incline_sat[9], incline_sat} + 11'sd256;

  always_comb begin
    incline_lim = incline_factor[8:0];
    if (incline_factor[10])
      incline_lim = 9'd0;
    else if (incline_factor[9])
      incline_lim = 9'd511;
  end

  assign cadence_factor = (cadence > 5'd1) ? ({1'b0, cadence} + 6'd32) : 6'd0;

  assign torque_off = {1'b0, avg_torque} - {1'b0, TORQUE_MIN};
  assign torque_pos = torque_off[12] ? 12'd0 : torque_off[11:0];

  // 12+9+6+3 = 30 bits holds the worst-case product, so nothing wraps before saturation.
  assign assist_prod = not_pedaling ? 30'd0 :
                       30'(torque_pos) * 30'(incline_lim) * 30'(cadence_factor) * 30'(scale);

  assign target_next = (|assist_prod[29:26]) ? 12'hFFF : assist_prod[25:14];

`ifdef DESIRED_DRIVE_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      target_curr <= 12'h000;
    else
      target_curr <= target_next;
  end
`else
  // clk and rst_n are deliberately idle in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};
  assign target_curr = target_next;
`endif

endmodule

// File: tb/tb_desired_drive_core.sv
// tb/tb_desired_drive_core.sv - self-checking bench for desired_drive_core against an arithmetic reference model
module tb_desired_drive_core;

  localparam logic [11:0] TMIN = 12'h380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] avg_torque = '0;
  logic [4:0]  cadence = '0;
  logic        not_pedaling = 1'b0;
  logic [12:0] incline = '0;
  logic [2:0]  scale = '0;
  logic [11:0] target_curr;

  int n_cmp = 0;
  int n_bad = 0;

  desired_drive_core #(.TORQUE_MIN(TMIN)) dut (
    .clk(clk), .rst_n(rst_n), .avg_torque(avg_torque), .cadence(cadence),
    .not_pedaling(not_pedaling), .incline(incline), .scale(scale),
    .target_curr(target_curr)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model(input int t, input int c, input bit np,
                                        input int inc, input int s);
    int sat, fac, lim, cf, tp;
    longint p;
    sat = (inc > 511) ? 511 : (inc < -512) ? -512 : inc;
    fac = sat + 256;
    lim = (fac < 0) ? 0 : (fac > 511) ? 511 : fac;
    cf  = (c > 1) ? c + 32 : 0;
    tp  = t - int'(TMIN);
    if (tp < 0) tp = 0;
    p = np ? 0 : longint'(tp) * lim * cf * s;
    if (p >= 64'd67108864) return 12'hFFF;
    return 12'((p >> 14) & 64'hFFF);
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    n_cmp++;
    assert (target_curr === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, target_curr, exp);
    end
  endtask

  task automatic settle();
`ifdef DESIRED_DRIVE_PIPE_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic apply(input logic [11:0] t, input logic [4:0] c, input logic np,
                       input logic [12:0] inc, input logic [2:0] s);
    avg_torque = t; cadence = c; not_pedaling = np; incline = inc; scale = s;
    settle();
  endtask

  task automatic vec(input string tag, input logic [11:0] t, input logic [4:0] c,
                     input logic np, input logic [12:0] inc, input logic [2:0] s);
    apply(t, c, np, inc, s);
    check(tag, model(int'(t), int'(c), np, int'($signed(inc)), int'(s)));
  endtask

  initial begin
    @(posedge clk);
    #1;
    avg_torque = 12'h800; cadence = 5'd16; not_pedaling = 1'b0; incline = 13'd0; scale = 3'd3;
    #1;
`ifdef DESIRED_DRIVE_PIPE_EN
    check("reset_hold", 12'h000);
    @(posedge clk);
    #1;
    check("reset_hold_edge", 12'h000);
    rst_n = 1'b1;
    #1;
    check("post_release_pre_edge", 12'h000);
    @(posedge clk);
    #1;
    check("first_edge_a20", 12'hA20);
    rst_n = 1'b0;
    #1;
    check("async_clear_midop", 12'h000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_a20", 12'hA20);
`else
    check("comb_in_reset", 12'hA20);
    rst_n = 1'b1;
    #1;
    check("rst_release_no_effect", 12'hA20);
    rst_n = 1'b0;
    #1;
    check("rst_assert_no_effect", 12'hA20);
    rst_n = 1'b1;
`endif

    apply(12'hFFF, 5'd31, 1'b1, 13'd0, 3'd7);      check("not_pedaling", 12'h000);
    apply(12'h800, 5'd16, 1'b0, 13'd0, 3'd3);      check("nominal_a20", 12'hA20);
    apply(12'hFFF, 5'd31, 1'b0, 13'h0FFF, 3'd7);   check("saturate", 12'hFFF);
    apply(12'h800, 5'd16, 1'b0, 13'h1ED4, 3'd3);   check("incline_m300", 12'h000);
    apply(12'h800, 5'd16, 1'b0, 13'h1F00, 3'd3);   check("incline_m256", 12'h000);
    apply(12'h380, 5'd16, 1'b0, 13'd0, 3'd3);      check("torque_at_min", 12'h000);
    apply(12'h800, 5'd1, 1'b0, 13'd0, 3'd3);       check("cadence_1", 12'h000);
    apply(12'h800, 5'd16, 1'b0, 13'd0, 3'd0);      check("scale_0", 12'h000);
    vec("cadence_2", 12'h800, 5'd2, 1'b0, 13'd0, 3'd3);
    vec("incline_pos_big", 12'h500, 5'd8, 1'b0, 13'h0200, 3'd1);
    vec("incline_neg_max", 12'h900, 5'd20, 1'b0, 13'h1000, 3'd5);

    for (int i = 0; i < 1500; i++) begin
      logic [12:0] inc;
      inc = (i % 3 == 0) ? 13'($urandom) : 13'($urandom_range(0, 1100) - 550);
      vec("random", 12'($urandom), 5'($urandom), ($urandom_range(0, 9) == 0), inc,
          3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
